// File: rtl/ov5640_dvp_capture.sv
`default_nettype none
// ============================================================================
// ov5640_dvp_capture : OV5640 8-bit DVP (RGB565) capture with frame skip,
//                      pixel coordinates and sticky line/byte error flags.
// Revision 1.0 - initial release
// ============================================================================
module ov5640_dvp_capture #(
   parameter int H_RES       = 1280,
   parameter int V_RES       = 720,
   parameter int SKIP_FRAMES = 4
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_enable,
   input  logic        I_vsync,
   input  logic        I_href,
   input  logic [7:0]  I_data,
   output logic        O_pix_valid,
   output logic [15:0] O_pix_data,
   output logic        O_sof,
   output logic        O_eol,
   output logic [11:0] O_x,
   output logic [11:0] O_y,
   output logic [15:0] O_frame_cnt,
   output logic        O_err_line_len,
   output logic        O_err_odd_bytes,
   output logic        O_busy
);

   localparam logic [11:0] c_h_res  = 12'(H_RES);
   localparam logic [11:0] c_h_last = 12'(H_RES - 1);
   localparam logic [11:0] c_v_res  = 12'(V_RES);
   localparam logic [7:0]  c_skip   = 8'(SKIP_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SKIP   = 2'd1,
      S_SYNC   = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_vs, r_hs, r_vs_d1, r_hs_d1;
   logic [7:0]  r_d;
   logic [7:0]  r_hi;
   logic        r_phase;
   logic [11:0] r_x, r_y;
   logic [7:0]  r_skip;
   logic        r_pend, r_pend_sof, r_pend_eol;
   logic [15:0] r_pend_data;
   logic [11:0] r_pend_x, r_pend_y;

   logic        w_vs_rise, w_hs_fall;
   logic [11:0] w_y_closed;

   assign w_vs_rise  = r_vs & ~r_vs_d1;
   assign w_hs_fall  = ~r_hs & r_hs_d1;
   // line index after closing a line that ends in this cycle; frame check uses it
   assign w_y_closed = (w_hs_fall && (r_y != c_v_res)) ? r_y + 12'd1 : r_y;

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         r_state         <= S_IDLE;
         r_vs            <= 1'b0;
         r_hs            <= 1'b0;
         r_vs_d1         <= 1'b0;
         r_hs_d1         <= 1'b0;
         r_d             <= 8'd0;
         r_hi            <= 8'd0;
         r_phase         <= 1'b0;
         r_x             <= 12'd0;
         r_y             <= 12'd0;
         r_skip          <= 8'd0;
         r_pend          <= 1'b0;
         r_pend_sof      <= 1'b0;
         r_pend_eol      <= 1'b0;
         r_pend_data     <= 16'd0;
         r_pend_x        <= 12'd0;
         r_pend_y        <= 12'd0;
         O_pix_valid     <= 1'b0;
         O_pix_data      <= 16'd0;
         O_sof           <= 1'b0;
         O_eol           <= 1'b0;
         O_x             <= 12'd0;
         O_y             <= 12'd0;
         O_frame_cnt     <= 16'd0;
         O_err_line_len  <= 1'b0;
         O_err_odd_bytes <= 1'b0;
         O_busy          <= 1'b0;
      end else begin
         r_vs    <= I_vsync;
         r_hs    <= I_href;
         r_d     <= I_data;
         r_vs_d1 <= r_vs;
         r_hs_d1 <= r_hs;

         // pixel formed last cycle is presented one cycle later
         r_pend      <= 1'b0;
         O_pix_valid <= r_pend;
         O_sof       <= r_pend & r_pend_sof;
         O_eol       <= r_pend & r_pend_eol;
         if (r_pend) begin
            O_pix_data <= r_pend_data;
            O_x        <= r_pend_x;
            O_y        <= r_pend_y;
         end

         case (r_state)
            S_IDLE: begin
               if (I_enable) begin
                  O_err_line_len  <= 1'b0;
                  O_err_odd_bytes <= 1'b0;
                  r_skip          <= 8'd0;
                  r_state         <= (SKIP_FRAMES == 0) ? S_SYNC : S_SKIP;
               end
            end
            S_SKIP: begin
               if (w_vs_rise) begin
                  r_skip <= r_skip + 8'd1;
                  if (r_skip + 8'd1 == c_skip)
                     r_state <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (w_vs_rise) begin
                  r_state <= S_ACTIVE;
                  O_busy  <= 1'b1;
                  r_x     <= 12'd0;
                  r_y     <= 12'd0;
                  r_phase <= 1'b0;
               end
            end
            S_ACTIVE: begin
               if (w_hs_fall) begin
                  if (r_x != c_h_res) O_err_line_len  <= 1'b1;
                  if (r_phase)        O_err_odd_bytes <= 1'b1;
                  r_x     <= 12'd0;
                  r_phase <= 1'b0;
                  r_y     <= w_y_closed;
               end else if (r_hs && !w_vs_rise) begin
                  if (!r_phase) begin
                     r_hi    <= r_d;
                     r_phase <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     // keep counting past H_RES so over-long lines are flagged
                     if (r_x != 12'hFFF) r_x <= r_x + 12'd1;
                     if ((r_x < c_h_res) && (r_y < c_v_res)) begin
                        r_pend      <= 1'b1;
                        r_pend_data <= {r_hi, r_d};
                        r_pend_x    <= r_x;
                        r_pend_y    <= r_y;
                        r_pend_sof  <= (r_x == 12'd0) && (r_y == 12'd0);
                        r_pend_eol  <= (r_x == c_h_last);
                     end
                  end
               end
               if (w_vs_rise) begin
                  if (w_y_closed == c_v_res) O_frame_cnt <= O_frame_cnt + 16'd1;
                  r_x     <= 12'd0;
                  r_y     <= 12'd0;
                  r_phase <= 1'b0;
                  if (!I_enable) begin
                     r_state <= S_IDLE;
                     O_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ov5640_dvp_capture.sv
`default_nettype none
// ============================================================================
// tb_ov5640_dvp_capture : scoreboard bench for the DVP capture block.
// Revision 1.0 - initial release
// ============================================================================
module tb_ov5640_dvp_capture;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int SK = 2;

   logic        clk = 1'b0;
   logic        I_rst_n, I_enable, I_vsync, I_href;
   logic [7:0]  I_data;
   logic        O_pix_valid, O_sof, O_eol, O_err_line_len, O_err_odd_bytes, O_busy;
   logic [15:0] O_pix_data, O_frame_cnt;
   logic [11:0] O_x, O_y;

   ov5640_dvp_capture #(.H_RES(H), .V_RES(V), .SKIP_FRAMES(SK)) dut (
      .I_clk(clk), .I_rst_n(I_rst_n), .I_enable(I_enable),
      .I_vsync(I_vsync), .I_href(I_href), .I_data(I_data),
      .O_pix_valid(O_pix_valid), .O_pix_data(O_pix_data),
      .O_sof(O_sof), .O_eol(O_eol), .O_x(O_x), .O_y(O_y),
      .O_frame_cnt(O_frame_cnt), .O_err_line_len(O_err_line_len),
      .O_err_odd_bytes(O_err_odd_bytes), .O_busy(O_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] pix;
   } vec_t;

   typedef struct {
      logic [15:0] pix;
      logic [11:0] x;
      logic [11:0] y;
      logic        sof;
      logic        eol;
      int          cyc;
   } exp_t;

   vec_t tab [H];
   exp_t q [$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // every strobe must match the head of the queue, on the expected cycle
   always @(negedge clk) begin
      exp_t e;
      if (O_pix_valid === 1'b1) begin
         n_checks++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL pix_unexpected: strobe data=0x%04h x=%0d y=%0d at cycle %0d, expected no strobe",
                     O_pix_data, O_x, O_y, cyc);
         end else begin
            e = q.pop_front();
            if ({O_pix_data, O_x, O_y, O_sof, O_eol} !== {e.pix, e.x, e.y, e.sof, e.eol} || cyc != e.cyc) begin
               n_err++;
               $display("FAIL pix: got data=0x%04h x=%0d y=%0d sof=%b eol=%b cyc=%0d, expected data=0x%04h x=%0d y=%0d sof=%b eol=%b cyc=%0d",
                        O_pix_data, O_x, O_y, O_sof, O_eol, cyc, e.pix, e.x, e.y, e.sof, e.eol, e.cyc);
            end
         end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         n_checks++;
         n_err++;
         e = q.pop_front();
         $display("FAIL pix_missing: no strobe at cycle %0d, expected data=0x%04h x=%0d y=%0d",
                  cyc, e.pix, e.x, e.y);
      end
   end

   task automatic drive(input logic vs, input logic hs, input logic [7:0] d);
      I_vsync = vs;
      I_href  = hs;
      I_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic vsync_pulse();
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      repeat (3) drive(1'b0, 1'b0, 8'h00);
   endtask

   // Ramp line; each completed byte pair inside the window is expected 3 cycles
   // after its second byte is driven (input register + pairing + output stage).
   task automatic send_line(input int nbytes, input int ly, input bit want, input bit tail);
      logic [7:0] v;
      logic [7:0] hi;
      exp_t       e;
      hi = 8'h00;
      for (int b = 0; b < nbytes; b++) begin
         v = 8'(ly * 37 + b * 5 + 3);
         if (b % 2 == 0) begin
            hi = v;
         end else if (want && (b / 2) < H && ly < V) begin
            e.pix = {hi, v};
            e.x   = 12'(b / 2);
            e.y   = 12'(ly);
            e.sof = (b / 2 == 0) && (ly == 0);
            e.eol = (b / 2 == H - 1);
            e.cyc = cyc + 3;
            q.push_back(e);
         end
         drive(1'b0, 1'b1, v);
      end
      if (tail) repeat (4) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input bit want);
      vsync_pulse();
      for (int ly = 0; ly < V; ly++) send_line(2 * H, ly, want, 1'b1);
   endtask

   initial begin
      exp_t e;
      int   rcyc;

      tab[0] = '{8'hF8, 8'h00, 16'hF800};
      tab[1] = '{8'h07, 8'hE0, 16'h07E0};
      tab[2] = '{8'h00, 8'h1F, 16'h001F};
      tab[3] = '{8'hFF, 8'hFF, 16'hFFFF};
      tab[4] = '{8'h00, 8'h00, 16'h0000};
      tab[5] = '{8'hA5, 8'h5A, 16'hA55A};
      tab[6] = '{8'h12, 8'h34, 16'h1234};
      tab[7] = '{8'h80, 8'h01, 16'h8001};

      I_rst_n = 1'b0; I_enable = 1'b0; I_vsync = 1'b0; I_href = 1'b0; I_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid",   32'(O_pix_valid),     32'd0);
      chk("reset_data",    32'(O_pix_data),      32'd0);
      chk("reset_xy",      32'({O_x, O_y}),      32'd0);
      chk("reset_fcnt",    32'(O_frame_cnt),     32'd0);
      chk("reset_flags",   32'({O_sof, O_eol, O_err_line_len, O_err_odd_bytes, O_busy}), 32'd0);

      I_rst_n = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 8'h00);
      I_enable = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      chk("busy_in_skip", 32'(O_busy), 32'd0);

      // two skipped frames, then the first captured frame opens with the table line
      send_frame(1'b0);
      send_frame(1'b0);
      vsync_pulse();
      chk("busy_active", 32'(O_busy), 32'd1);
      for (int i = 0; i < H; i++) begin
         drive(1'b0, 1'b1, tab[i].b0);
         e.pix = tab[i].pix;
         e.x   = 12'(i);
         e.y   = 12'd0;
         e.sof = (i == 0);
         e.eol = (i == H - 1);
         e.cyc = cyc + 3;
         q.push_back(e);
         drive(1'b0, 1'b1, tab[i].b1);
      end
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      for (int ly = 1; ly < V; ly++) send_line(2 * H, ly, 1'b1, 1'b1);
      send_frame(1'b1);
      vsync_pulse();
      chk("frame_cnt_two",   32'(O_frame_cnt),     32'd2);
      chk("no_line_err",     32'(O_err_line_len),  32'd0);
      chk("no_odd_err",      32'(O_err_odd_bytes), 32'd0);

      // short line
      send_line(2 * H - 2, 0, 1'b1, 1'b1);
      chk("short_line_err",  32'(O_err_line_len),  32'd1);
      for (int ly = 1; ly < V; ly++) send_line(2 * H, ly, 1'b1, 1'b1);
      chk("short_no_odd",    32'(O_err_odd_bytes), 32'd0);

      // reset in the middle of a line
      vsync_pulse();
      send_line(5, 0, 1'b1, 1'b0);
      I_rst_n = 1'b0;
      I_href  = 1'b0;
      rcyc = cyc + 1;
      while (q.size() > 0 && q[q.size() - 1].cyc >= rcyc) void'(q.pop_back());
      @(posedge clk);
      #1;
      chk("midrst_valid",  32'(O_pix_valid),  32'd0);
      chk("midrst_data",   32'(O_pix_data),   32'd0);
      chk("midrst_xy",     32'({O_x, O_y}),   32'd0);
      chk("midrst_fcnt",   32'(O_frame_cnt),  32'd0);
      chk("midrst_flags",  32'({O_sof, O_eol, O_err_line_len, O_err_odd_bytes, O_busy}), 32'd0);
      I_rst_n = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 8'h00);

      // line with one stray byte
      send_frame(1'b0);
      send_frame(1'b0);
      vsync_pulse();
      send_line(2 * H + 1, 0, 1'b1, 1'b1);
      chk("odd_bytes_err",   32'(O_err_odd_bytes), 32'd1);
      chk("odd_no_line_err", 32'(O_err_line_len),  32'd0);
      for (int ly = 1; ly < V; ly++) send_line(2 * H, ly, 1'b1, 1'b1);

      // enable dropped mid-frame: frame completes, exit at next vsync
      vsync_pulse();
      chk("frame_cnt_one", 32'(O_frame_cnt), 32'd1);
      send_line(2 * H, 0, 1'b1, 1'b1);
      send_line(2 * H, 1, 1'b1, 1'b1);
      I_enable = 1'b0;
      send_line(2 * H, 2, 1'b1, 1'b1);
      send_line(2 * H, 3, 1'b1, 1'b1);
      chk("busy_before_exit", 32'(O_busy), 32'd1);
      vsync_pulse();
      chk("busy_after_exit",  32'(O_busy),      32'd0);
      chk("frame_cnt_final",  32'(O_frame_cnt), 32'd2);
      send_frame(1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #1;
      chk("scoreboard_drain", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
